// File: rtl/hz_bcd_convertidor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hz_bcd_convertidor_pkg
//  Description : Shared constants for the frequency binary-to-BCD stage:
//                input width, digit count, saturation ceiling, BCD nibble
//                width, derived register widths, FSM state encodings and a
//                saturation helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package hz_bcd_convertidor_pkg;

    localparam int N_BIN  = 14;                 // width of freq_Hz
    localparam int N_DIG  = 5;                  // BCD digits produced
    localparam int F_MAX  = 10000;              // saturation ceiling
    localparam int NIB_W  = 4;                  // bits per BCD digit

    localparam int BCD_W  = NIB_W * N_DIG;      // 20-bit packed digit field
    localparam int WORK_W = BCD_W + N_BIN;      // 34-bit double-dabble register
    localparam int CNT_W  = $clog2(N_BIN);      // shift counter width

    localparam logic [N_BIN-1:0] F_MAX_BIN = N_BIN'(F_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(N_BIN - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    // Clamp the incoming frequency so the result always fits in N_DIG digits.
    function automatic logic [N_BIN-1:0] saturate(input logic [N_BIN-1:0] v);
        return (v > F_MAX_BIN) ? F_MAX_BIN : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hz_bcd_convertidor_dd_ajuste_digito.sv
`default_nettype none
// ============================================================================
//  Module      : dd_ajuste_digito
//  Description : Combinational double-dabble digit corrector. A nibble that
//                is 5 or more gets 3 added so that the following left shift
//                carries correctly into the next decimal digit.
//  Ports       : i_nib [3:0]  BCD nibble before correction
//                o_nib [3:0]  corrected nibble
//  Revision    : 1.0 - initial release
// ============================================================================
module dd_ajuste_digito
    import hz_bcd_convertidor_pkg::*;
(
    input  logic [NIB_W-1:0] i_nib,
    output logic [NIB_W-1:0] o_nib
);

    assign o_nib = (i_nib >= NIB_W'(5)) ? (i_nib + NIB_W'(3)) : i_nib;

endmodule

`default_nettype wire

// File: rtl/hz_bcd_convertidor.sv
`default_nettype none
// ============================================================================
//  Module      : hz_bcd_convertidor
//  Description : Per-frame binary-to-BCD converter for the on-screen
//                frequency readout. Captures freq_Hz (saturated to F_MAX) on
//                frame_start, runs N_BIN shift-add-3 steps, then publishes
//                the digits and a leading-zero blanking mask in one edge.
//  Ports       : NCLK         pixel clock
//                NRST         asynchronous active-low reset
//                freq_Hz      binary frequency, 0..F_MAX (larger saturates)
//                frame_start  one-cycle frame-start pulse
//                bcd          [19:16] ten-thousands .. [3:0] units
//                digit_on     bit i set when digit i is displayed
//                busy         conversion in progress
//                upd          one-cycle pulse after bcd/digit_on update
//  Options     : HZ_BCD_SKIP_SAME_EN - skip conversions whose saturated
//                input equals the last committed value.
//  Revision    : 1.0 - initial release
// ============================================================================
module hz_bcd_convertidor
    import hz_bcd_convertidor_pkg::*;
(
    input  logic              NCLK,
    input  logic              NRST,
    input  logic [N_BIN-1:0]  freq_Hz,
    input  logic              frame_start,
    output logic [BCD_W-1:0]  bcd,
    output logic [N_DIG-1:0]  digit_on,
    output logic              busy,
    output logic              upd
);

    logic [1:0]        r_state;
    logic [WORK_W-1:0] r_work;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_pending;
    logic [BCD_W-1:0]  r_bcd;
    logic [N_DIG-1:0]  r_digit_on;
    logic              r_busy;
    logic              r_upd;

    logic [N_BIN-1:0]  w_sat;
    logic              w_start;
    logic              w_same;
    logic [BCD_W-1:0]  w_bcd_adj;
    logic [N_DIG-1:0]  w_digit_on;

    assign w_sat   = saturate(freq_Hz);
    assign w_start = frame_start | r_pending;

    // ------------------------------------------------------------------------
    // Per-digit add-3 correction on the BCD half of the work register.
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < N_DIG; g++) begin : g_ajuste
        dd_ajuste_digito u_ajuste (
            .i_nib (r_work[N_BIN + g*NIB_W +: NIB_W]),
            .o_nib (w_bcd_adj[g*NIB_W +: NIB_W])
        );
    end

    // ------------------------------------------------------------------------
    // Leading-zero blanking: digit i is shown when it or any more significant
    // digit is nonzero; the units digit is always shown.
    // ------------------------------------------------------------------------
    always_comb begin
        logic v_any;
        v_any      = 1'b0;
        w_digit_on = '0;
        for (int i = N_DIG-1; i >= 1; i--) begin
            v_any         = v_any | (r_work[N_BIN + i*NIB_W +: NIB_W] != '0);
            w_digit_on[i] = v_any;
        end
        w_digit_on[0] = 1'b1;
    end

    // ------------------------------------------------------------------------
    // Optional repeat suppression. The captured value is parked in r_cap
    // because the binary half of the work register is shifted away.
    // ------------------------------------------------------------------------
`ifdef HZ_BCD_SKIP_SAME_EN
    logic [N_BIN-1:0] r_cap;
    logic [N_BIN-1:0] r_last;
    logic             r_last_vld;

    assign w_same = r_last_vld && (w_sat == r_last);

    always_ff @(posedge NCLK or negedge NRST) begin
        if (!NRST) begin
            r_cap      <= '0;
            r_last     <= '0;
            r_last_vld <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && w_start && !w_same) begin
                r_cap <= w_sat;
            end
            if (r_state == ST_COMMIT) begin
                r_last     <= r_cap;
                r_last_vld <= 1'b1;
            end
        end
    end
`else
    assign w_same = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Control FSM and double-dabble datapath.
    // ------------------------------------------------------------------------
    always_ff @(posedge NCLK or negedge NRST) begin
        if (!NRST) begin
            r_state    <= ST_IDLE;
            r_work     <= '0;
            r_cnt      <= '0;
            r_pending  <= 1'b0;
            r_bcd      <= '0;
            r_digit_on <= N_DIG'(1);
            r_busy     <= 1'b0;
            r_upd      <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_pending <= 1'b0;
                        if (!w_same) begin
                            r_work  <= {{BCD_W{1'b0}}, w_sat};
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    // A frame start here is remembered, not restarted.
                    if (frame_start) begin
                        r_pending <= 1'b1;
                    end
                    // Correct the digits first, then shift, in the same edge.
                    r_work <= {w_bcd_adj, r_work[N_BIN-1:0]} << 1;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    if (frame_start) begin
                        r_pending <= 1'b1;
                    end
                    r_bcd      <= r_work[WORK_W-1:N_BIN];
                    r_digit_on <= w_digit_on;
                    r_busy     <= 1'b0;
                    r_upd      <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bcd      = r_bcd;
    assign digit_on = r_digit_on;
    assign busy     = r_busy;
    assign upd      = r_upd;

endmodule

`default_nettype wire

// File: tb/tb_hz_bcd_convertidor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hz_bcd_convertidor
//  Description : Self-checking bench for hz_bcd_convertidor. Expected digits
//                and blanking masks come from decimal arithmetic on the
//                saturated input value. Honours HZ_BCD_SKIP_SAME_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hz_bcd_convertidor;

    logic        NCLK;
    logic        NRST;
    logic [13:0] freq_Hz;
    logic        frame_start;
    logic [19:0] bcd;
    logic [4:0]  digit_on;
    logic        busy;
    logic        upd;

    int errors = 0;
    int checks = 0;

    hz_bcd_convertidor dut (
        .NCLK        (NCLK),
        .NRST        (NRST),
        .freq_Hz     (freq_Hz),
        .frame_start (frame_start),
        .bcd         (bcd),
        .digit_on    (digit_on),
        .busy        (busy),
        .upd         (upd)
    );

    initial NCLK = 1'b0;
    always #5 NCLK = ~NCLK;

    // ---------------- reference model ----------------
    function automatic int sat_of(input int f);
        return (f > 10000) ? 10000 : f;
    endfunction

    function automatic logic [19:0] model_bcd(input int f);
        int s;
        logic [19:0] r;
        s = sat_of(f);
        r = '0;
        for (int d = 0; d < 5; d++) begin
            r[d*4 +: 4] = 4'(s % 10);
            s = s / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] model_don(input int f);
        int s;
        int n;
        s = sat_of(f);
        n = 1;
        if (s >= 10)    n = 2;
        if (s >= 100)   n = 3;
        if (s >= 1000)  n = 4;
        if (s >= 10000) n = 5;
        return 5'((1 << n) - 1);
    endfunction

    // Stimulus only: pulse frame_start and observe one conversion.
    task automatic do_conv(input int f, output int lat, output bit busy_ok,
                           output logic [19:0] ob, output logic [4:0] od,
                           output logic upd_after);
        freq_Hz     = 14'(f);
        frame_start = 1'b1;
        @(posedge NCLK); #1;
        frame_start = 1'b0;
        busy_ok = (busy === 1'b1);
        lat = 0;
        while (lat < 40) begin
            @(posedge NCLK); #1;
            lat++;
            if (upd === 1'b1) break;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        ob = bcd;
        od = digit_on;
        @(posedge NCLK); #1;
        upd_after = upd;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int n_upd;
        NRST = 1'b1; freq_Hz = '0; frame_start = 1'b0;
        #2 NRST = 1'b0;
        #21;
        checks++; if (bcd !== 20'h0) begin errors++; $display("FAIL reset_bcd got=%h exp=%h", bcd, 20'h0); end
        checks++; if (digit_on !== 5'b00001) begin errors++; $display("FAIL reset_digit_on got=%b exp=%b", digit_on, 5'b00001); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (upd !== 1'b0) begin errors++; $display("FAIL reset_upd got=%b exp=0", upd); end
        @(posedge NCLK); #1;
        NRST = 1'b1;
        n_upd = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge NCLK); #1;
            if (upd === 1'b1 || busy !== 1'b0) n_upd++;
        end
        checks++; if (n_upd !== 0) begin errors++; $display("FAIL idle_activity got=%0d exp=0", n_upd); end
        checks++; if (bcd !== 20'h0 || digit_on !== 5'b00001) begin errors++; $display("FAIL idle_hold got=%h/%b exp=00000/00001", bcd, digit_on); end
    endtask

    task automatic test_basic();
        int lat; bit bok; logic [19:0] ob; logic [4:0] od; logic ua;
        do_conv(1234, lat, bok, ob, od, ua);
        checks++; if (!bok) begin errors++; $display("FAIL basic_busy got=drop exp=high_E0_to_E14"); end
        checks++; if (lat !== 15) begin errors++; $display("FAIL basic_latency got=%0d exp=15", lat); end
        checks++; if (ob !== model_bcd(1234)) begin errors++; $display("FAIL basic_bcd got=%h exp=%h", ob, model_bcd(1234)); end
        checks++; if (od !== model_don(1234)) begin errors++; $display("FAIL basic_digit_on got=%b exp=%b", od, model_don(1234)); end
        checks++; if (ua !== 1'b0) begin errors++; $display("FAIL basic_upd_width got=%b exp=0", ua); end
        repeat (5) @(posedge NCLK);
        #1;
        checks++; if (bcd !== model_bcd(1234) || busy !== 1'b0) begin errors++; $display("FAIL basic_hold got=%h busy=%b exp=%h busy=0", bcd, busy, model_bcd(1234)); end
    endtask

    task automatic test_boundaries();
        int vals[4] = '{16383, 0, 9, 10000};
        int prev;
        int f;
        int lat; bit bok; logic [19:0] ob; logic [4:0] od; logic ua;
        prev = 1234;
        for (int k = 0; k < 16; k++) begin
            if (k < 4) begin
                f = vals[k];
            end else begin
                f = int'($urandom_range(1000, 9999));
                if (k % 4 == 0) f = int'($urandom_range(10, 99));
                while (sat_of(f) == prev) f = f + 1;
            end
            do_conv(f, lat, bok, ob, od, ua);
            checks++; if (lat !== 15 || !bok) begin errors++; $display("FAIL conv_timing in=%0d got lat=%0d busy_ok=%0d exp lat=15 busy_ok=1", f, lat, bok); end
            checks++; if (ob !== model_bcd(f)) begin errors++; $display("FAIL conv_bcd in=%0d got=%h exp=%h", f, ob, model_bcd(f)); end
            checks++; if (od !== model_don(f)) begin errors++; $display("FAIL conv_digit_on in=%0d got=%b exp=%b", f, od, model_don(f)); end
            prev = sat_of(f);
        end
    endtask

    task automatic test_pulse_busy();
        int a_v[2]  = '{500, 42};
        int b_v[2]  = '{750, 43};
        int pe_v[2] = '{5, 15};
        int n_upd;
        int cyc_at[2];
        logic [19:0] bcd_at[2];
        for (int c = 0; c < 2; c++) begin
            n_upd = 0;
            cyc_at = '{0, 0};
            bcd_at = '{20'h0, 20'h0};
            freq_Hz = 14'(a_v[c]);
            frame_start = 1'b1;
            @(posedge NCLK); #1;
            frame_start = 1'b0;
            freq_Hz = 14'(b_v[c]);
            for (int cyc = 1; cyc <= 45; cyc++) begin
                if (cyc == pe_v[c]) frame_start = 1'b1;
                @(posedge NCLK); #1;
                frame_start = 1'b0;
                if (upd === 1'b1) begin
                    if (n_upd < 2) begin
                        cyc_at[n_upd] = cyc;
                        bcd_at[n_upd] = bcd;
                    end
                    n_upd++;
                end
            end
            checks++; if (n_upd !== 2) begin errors++; $display("FAIL pend%0d_upd_count got=%0d exp=2", c, n_upd); end
            checks++; if (cyc_at[0] !== 15 || bcd_at[0] !== model_bcd(a_v[c])) begin errors++; $display("FAIL pend%0d_first got cyc=%0d bcd=%h exp cyc=15 bcd=%h", c, cyc_at[0], bcd_at[0], model_bcd(a_v[c])); end
            checks++; if (cyc_at[1] !== 31 || bcd_at[1] !== model_bcd(b_v[c])) begin errors++; $display("FAIL pend%0d_second got cyc=%0d bcd=%h exp cyc=31 bcd=%h", c, cyc_at[1], bcd_at[1], model_bcd(b_v[c])); end
        end
    endtask

    task automatic test_reset_mid();
        int n_upd;
        int lat; bit bok; logic [19:0] ob; logic [4:0] od; logic ua;
        freq_Hz = 14'd4321;
        frame_start = 1'b1;
        @(posedge NCLK); #1;
        frame_start = 1'b0;
        repeat (6) @(posedge NCLK);
        #3;
        NRST = 1'b0;
        #1;
        checks++; if (bcd !== 20'h0 || digit_on !== 5'b00001) begin errors++; $display("FAIL midrst_outputs got=%h/%b exp=00000/00001", bcd, digit_on); end
        checks++; if (busy !== 1'b0 || upd !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got busy=%b upd=%b exp 0/0", busy, upd); end
        repeat (3) @(posedge NCLK);
        #1;
        NRST = 1'b1;
        n_upd = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge NCLK); #1;
            if (upd === 1'b1) n_upd++;
        end
        checks++; if (n_upd !== 0) begin errors++; $display("FAIL midrst_no_upd got=%0d exp=0", n_upd); end
        do_conv(4321, lat, bok, ob, od, ua);
        checks++; if (lat !== 15 || ob !== model_bcd(4321) || od !== model_don(4321)) begin errors++; $display("FAIL midrst_reconv got lat=%0d bcd=%h don=%b exp lat=15 bcd=%h don=%b", lat, ob, od, model_bcd(4321), model_don(4321)); end
    endtask

    task automatic test_skip_same();
        int n_upd;
        int n_busy;
        int exp_upd;
        int lat; bit bok; logic [19:0] ob; logic [4:0] od; logic ua;
        do_conv(2500, lat, bok, ob, od, ua);
        checks++; if (lat !== 15 || ob !== model_bcd(2500)) begin errors++; $display("FAIL same_first got lat=%0d bcd=%h exp lat=15 bcd=%h", lat, ob, model_bcd(2500)); end
        freq_Hz = 14'd2500;
        frame_start = 1'b1;
        n_upd = 0;
        n_busy = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge NCLK); #1;
            frame_start = 1'b0;
            if (upd === 1'b1) n_upd++;
            if (busy === 1'b1) n_busy++;
        end
`ifdef HZ_BCD_SKIP_SAME_EN
        exp_upd = 0;
`else
        exp_upd = 1;
`endif
        checks++; if (n_upd !== exp_upd) begin errors++; $display("FAIL same_second_upd got=%0d exp=%0d", n_upd, exp_upd); end
        checks++; if (n_busy !== exp_upd * 15) begin errors++; $display("FAIL same_second_busy got=%0d exp=%0d", n_busy, exp_upd * 15); end
        checks++; if (bcd !== model_bcd(2500) || digit_on !== model_don(2500)) begin errors++; $display("FAIL same_hold got=%h/%b exp=%h/%b", bcd, digit_on, model_bcd(2500), model_don(2500)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_pulse_busy();
        test_reset_mid();
        test_skip_same();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
